// File: rtl/mcs51_bus_pkg.sv
// Shared types and constants for the 8051-style external bus master.
`timescale 1ns/1ps
package mcs51_bus_pkg;

  localparam int CNT_W = 3;

  localparam int ALE_CYC_DEF    = 2;
  localparam int STROBE_CYC_DEF = 4;
  localparam int HOLD_CYC_DEF   = 1;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    LATCH,
    STROBE,
    HOLD,
    GAP
  } state_t;

  function automatic logic [CNT_W-1:0] cnt_load(int cyc);
    return CNT_W'(cyc - 1);
  endfunction

endpackage

// File: rtl/mcs51_phase_timer.sv
// Loadable down-counter for bus phase timing; zero marks the last
// clock of the current phase.
`timescale 1ns/1ps
module mcs51_phase_timer
  import mcs51_bus_pkg::*;
(
  input  logic             clock,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mcs51_bus_master.sv
// Multiplexed 8051-style bus initiator with Moore outputs.
// Define MCS51_BUS_GAP_EN to add a cs_n-high GAP state after HOLD.
`timescale 1ns/1ps
module mcs51_bus_master
  import mcs51_bus_pkg::*;
#(
  parameter int ALE_CYC    = ALE_CYC_DEF,
  parameter int STROBE_CYC = STROBE_CYC_DEF,
  parameter int HOLD_CYC   = HOLD_CYC_DEF
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        done,
  output logic [7:0]  rdata,
  output logic        cs_n,
  output logic        ale,
  output logic [7:0]  abus,
  output logic        w_n,
  output logic        r_n,
  output logic [7:0]  dbus_o,
  output logic        dbus_oe,
  input  logic [7:0]  dbus_i
);

  if (ALE_CYC < 1 || ALE_CYC > 8) begin : g_bad_ale
    $fatal(1, "ALE_CYC out of range");
  end
  if (STROBE_CYC < 2 || STROBE_CYC > 8) begin : g_bad_strobe
    $fatal(1, "STROBE_CYC out of range");
  end
  if (HOLD_CYC < 1 || HOLD_CYC > 8) begin : g_bad_hold
    $fatal(1, "HOLD_CYC out of range");
  end

  state_t           state;
  logic [15:0]      addr_q;
  logic [7:0]       wdata_q;
  logic             write_q;
  logic             tload;
  logic [CNT_W-1:0] tval;
  logic             zero;
  logic             hs;

  assign hs = req_valid && req_ready;

  // Timer reloads on the same edge that enters the next timed phase.
  always_comb begin
    tload = 1'b0;
    tval  = '0;
    unique case (state)
      IDLE: begin
        if (hs) begin
          tload = 1'b1;
          tval  = cnt_load(ALE_CYC);
        end
      end
      LATCH: begin
        tload = 1'b1;
        tval  = cnt_load(STROBE_CYC);
      end
      STROBE: begin
        if (zero) begin
          tload = 1'b1;
          tval  = cnt_load(HOLD_CYC);
        end
      end
      default: begin
        tload = 1'b0;
        tval  = '0;
      end
    endcase
  end

  mcs51_phase_timer u_timer (
    .clock    (clock),
    .rst      (rst),
    .load     (tload),
    .load_val (tval),
    .zero     (zero)
  );

  always_ff @(posedge clock) begin
    if (rst) begin
      state     <= IDLE;
      cs_n      <= 1'b1;
      ale       <= 1'b0;
      w_n       <= 1'b1;
      r_n       <= 1'b1;
      dbus_oe   <= 1'b0;
      dbus_o    <= '0;
      abus      <= '0;
      done      <= 1'b0;
      rdata     <= '0;
      req_ready <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          req_ready <= 1'b1;
          cs_n      <= 1'b1;
          if (hs) begin
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            write_q   <= req_write;
            req_ready <= 1'b0;
            cs_n      <= 1'b0;
            ale       <= 1'b1;
            abus      <= req_addr[15:8];
            dbus_o    <= req_addr[7:0];
            dbus_oe   <= 1'b1;
            state     <= ADDR;
          end
        end
        ADDR: begin
          if (zero) begin
            ale   <= 1'b0;
            state <= LATCH;
          end
        end
        LATCH: begin
          state <= STROBE;
          if (write_q) begin
            w_n    <= 1'b0;
            dbus_o <= wdata_q;
          end else begin
            r_n     <= 1'b0;
            dbus_oe <= 1'b0;
          end
        end
        STROBE: begin
          if (zero) begin
            w_n   <= 1'b1;
            r_n   <= 1'b1;
            state <= HOLD;
            if (!write_q) begin
              rdata <= dbus_i;
            end
          end
        end
        HOLD: begin
          if (zero) begin
            cs_n    <= 1'b1;
            dbus_oe <= 1'b0;
            dbus_o  <= '0;
`ifdef MCS51_BUS_GAP_EN
            state   <= GAP;
`else
            state     <= IDLE;
            done      <= 1'b1;
            req_ready <= 1'b1;
`endif
          end
        end
        GAP: begin
          state     <= IDLE;
          done      <= 1'b1;
          req_ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mcs51_bus_master.sv
// Directed self-checking bench for mcs51_bus_master (default and
// 1/2/3 phase configurations).
`timescale 1ns/1ps
module tb_mcs51_bus_master;

`define CHK(t, o, e) begin total++; assert ((o) === (e)) else begin bad++; $error("FAIL %s obs=%0h exp=%0h", t, o, e); end end

`ifdef MCS51_BUS_GAP_EN
  localparam int GAP_EXP = 2;
`else
  localparam int GAP_EXP = 1;
`endif

  logic clock = 1'b0;
  logic rst   = 1'b1;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  logic        req_valid, req_ready, req_write, done;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata, rdata, abus, dbus_o, dbus_i;
  logic        cs_n, ale, w_n, r_n, dbus_oe;

  logic        req_valid_b, req_ready_b, req_write_b, done_b;
  logic [15:0] req_addr_b;
  logic [7:0]  req_wdata_b, rdata_b, abus_b, dbus_o_b, dbus_i_b;
  logic        cs_n_b, ale_b, w_n_b, r_n_b, dbus_oe_b;

  assign dbus_i   = r_n ? 8'hFF : 8'h3C;
  assign dbus_i_b = 8'h00;

  mcs51_bus_master dut (
    .clock(clock), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .done(done), .rdata(rdata),
    .cs_n(cs_n), .ale(ale), .abus(abus), .w_n(w_n), .r_n(r_n),
    .dbus_o(dbus_o), .dbus_oe(dbus_oe), .dbus_i(dbus_i)
  );

  mcs51_bus_master #(
    .ALE_CYC(1), .STROBE_CYC(2), .HOLD_CYC(3)
  ) dut_b (
    .clock(clock), .rst(rst),
    .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_write(req_write_b), .req_addr(req_addr_b),
    .req_wdata(req_wdata_b), .done(done_b), .rdata(rdata_b),
    .cs_n(cs_n_b), .ale(ale_b), .abus(abus_b), .w_n(w_n_b),
    .r_n(r_n_b), .dbus_o(dbus_o_b), .dbus_oe(dbus_oe_b),
    .dbus_i(dbus_i_b)
  );

  int cs_cnt, ale_cnt, wn_cnt, rn_cnt, mid_cnt, done_cnt;
  int oe_bad, wrise, hi_run, last_gap, tx_cnt;
  logic [7:0] ale_abus, ale_dbus, wn_dbus;
  logic cs_prev = 1'b1;
  logic w_prev  = 1'b1;

  int cs_cnt_b, ale_cnt_b, wn_cnt_b, mid_cnt_b, done_cnt_b, wrise_b;
  logic w_prev_b = 1'b1;

  always @(posedge clock) begin
    #1;
    if (!cs_n) begin
      cs_cnt++;
      if (cs_prev) begin
        tx_cnt++;
        last_gap = hi_run;
      end
      hi_run = 0;
    end else begin
      hi_run++;
    end
    if (ale) begin
      ale_cnt++;
      ale_abus = abus;
      ale_dbus = dbus_o;
    end
    if (!w_n) begin
      wn_cnt++;
      wn_dbus = dbus_o;
    end
    if (!r_n) begin
      rn_cnt++;
      if (dbus_oe) oe_bad++;
    end
    if (!cs_n && !ale && w_n && r_n) mid_cnt++;
    if (w_n && !w_prev && !cs_n) wrise++;
    if (done) done_cnt++;
    cs_prev = cs_n;
    w_prev  = w_n;
    if (!cs_n_b) cs_cnt_b++;
    if (ale_b) ale_cnt_b++;
    if (!w_n_b) wn_cnt_b++;
    if (!cs_n_b && !ale_b && w_n_b && r_n_b) mid_cnt_b++;
    if (w_n_b && !w_prev_b && !cs_n_b) wrise_b++;
    if (done_b) done_cnt_b++;
    w_prev_b = w_n_b;
  end

  task automatic clr();
    cs_cnt = 0; ale_cnt = 0; wn_cnt = 0; rn_cnt = 0;
    mid_cnt = 0; done_cnt = 0; oe_bad = 0; wrise = 0;
    tx_cnt = 0;
    ale_abus = '0; ale_dbus = '0; wn_dbus = '0;
    cs_cnt_b = 0; ale_cnt_b = 0; wn_cnt_b = 0;
    mid_cnt_b = 0; done_cnt_b = 0; wrise_b = 0;
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic wait_accept();
    int n = 0;
    while (!req_ready && n < 40) begin
      step();
      n++;
    end
    `CHK("accept_ready", req_ready, 1'b1)
    step();
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 40) begin
      step();
      n++;
    end
    `CHK("done_seen", done, 1'b1)
  endtask

  initial begin
    int n;
    req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0;
    req_valid_b = 0; req_write_b = 0; req_addr_b = '0; req_wdata_b = '0;
    clr();
    hi_run = 0; last_gap = 0;
    rst = 1'b1;
    step(); step(); step();
    `CHK("rst_cs_n", cs_n, 1'b1)
    `CHK("rst_ale", ale, 1'b0)
    `CHK("rst_w_n", w_n, 1'b1)
    `CHK("rst_r_n", r_n, 1'b1)
    `CHK("rst_oe", dbus_oe, 1'b0)
    `CHK("rst_dbus_o", dbus_o, 8'h00)
    `CHK("rst_abus", abus, 8'h00)
    `CHK("rst_done", done, 1'b0)
    `CHK("rst_rdata", rdata, 8'h00)
    `CHK("rst_ready", req_ready, 1'b0)
    rst = 1'b0;
    step();
    `CHK("idle_ready", req_ready, 1'b1)

    // single write
    clr();
    req_write = 1; req_addr = 16'h1234; req_wdata = 8'hA5; req_valid = 1;
    wait_accept();
    req_valid = 0;
    wait_done();
    step(); step(); step();
    `CHK("wr_ale_cnt", ale_cnt, 2)
    `CHK("wr_ale_abus", ale_abus, 8'h12)
    `CHK("wr_ale_dbus", ale_dbus, 8'h34)
    `CHK("wr_wn_cnt", wn_cnt, 4)
    `CHK("wr_wn_dbus", wn_dbus, 8'hA5)
    `CHK("wr_cs_cnt", cs_cnt, 8)
    `CHK("wr_mid_cnt", mid_cnt, 2)
    `CHK("wr_wrise", wrise, 1)
    `CHK("wr_done_cnt", done_cnt, 1)
    `CHK("wr_rn_cnt", rn_cnt, 0)

    // single read
    clr();
    req_write = 0; req_addr = 16'h0210; req_valid = 1;
    wait_accept();
    req_valid = 0;
    wait_done();
    `CHK("rd_rdata", rdata, 8'h3C)
    step(); step();
    `CHK("rd_rn_cnt", rn_cnt, 4)
    `CHK("rd_oe_bad", oe_bad, 0)
    `CHK("rd_wn_cnt", wn_cnt, 0)
    `CHK("rd_cs_cnt", cs_cnt, 8)
    `CHK("rd_ale_abus", ale_abus, 8'h02)
    `CHK("rd_ale_dbus", ale_dbus, 8'h10)
    `CHK("rd_rdata_hold", rdata, 8'h3C)

    // back-to-back writes
    clr();
    req_write = 1; req_addr = 16'h1111; req_wdata = 8'h01; req_valid = 1;
    wait_accept();
    req_addr = 16'h2222; req_wdata = 8'h02;
    wait_done();
    wait_accept();
    req_valid = 0;
    wait_done();
    step(); step();
    `CHK("b2b_gap", last_gap, GAP_EXP)
    `CHK("b2b_abus2", ale_abus, 8'h22)
    `CHK("b2b_wdata2", wn_dbus, 8'h02)
    `CHK("b2b_tx_cnt", tx_cnt, 2)
    `CHK("b2b_done_cnt", done_cnt, 2)
    `CHK("b2b_cs_cnt", cs_cnt, 16)

    // reset in the third strobe clock
    clr();
    req_write = 1; req_addr = 16'h5A5A; req_wdata = 8'hC3; req_valid = 1;
    wait_accept();
    req_valid = 0;
    n = 0;
    while (w_n && n < 20) begin
      step();
      n++;
    end
    `CHK("rs_strobe_seen", w_n, 1'b0)
    step(); step();
    rst = 1'b1;
    step();
    `CHK("rs_cs_n", cs_n, 1'b1)
    `CHK("rs_w_n", w_n, 1'b1)
    `CHK("rs_oe", dbus_oe, 1'b0)
    `CHK("rs_done", done, 1'b0)
    rst = 1'b0;
    step(); step();
    `CHK("rs_no_done", done_cnt, 0)
    clr();
    req_addr = 16'h5678; req_wdata = 8'h9E; req_valid = 1;
    wait_accept();
    req_valid = 0;
    wait_done();
    step();
    `CHK("rs_new_abus", ale_abus, 8'h56)
    `CHK("rs_new_wdata", wn_dbus, 8'h9E)
    `CHK("rs_new_cs_cnt", cs_cnt, 8)

    // req_valid toggling while busy
    clr();
    req_write = 1; req_addr = 16'hAAAA; req_wdata = 8'h11; req_valid = 1;
    wait_accept();
    for (int i = 0; i < 6; i++) begin
      req_valid = ~req_valid;
      req_addr  = req_addr + 16'h0101;
      req_wdata = req_wdata + 8'h01;
      `CHK("tg_busy_ready", req_ready, 1'b0)
      step();
    end
    req_valid = 0;
    wait_done();
    step(); step();
    `CHK("tg_tx_cnt", tx_cnt, 1)
    `CHK("tg_abus", ale_abus, 8'hAA)
    `CHK("tg_dbus", ale_dbus, 8'hAA)
    `CHK("tg_wdata", wn_dbus, 8'h11)
    `CHK("tg_done_cnt", done_cnt, 1)

    // short-phase instance 1/2/3
    clr();
    req_write_b = 1; req_addr_b = 16'hBEEF; req_wdata_b = 8'h77;
    req_valid_b = 1;
    n = 0;
    while (!req_ready_b && n < 20) begin
      step();
      n++;
    end
    `CHK("p_ready", req_ready_b, 1'b1)
    step();
    req_valid_b = 0;
    n = 0;
    while (!done_b && n < 40) begin
      step();
      n++;
    end
    `CHK("p_done_seen", done_b, 1'b1)
    step(); step();
    `CHK("p_cs_cnt", cs_cnt_b, 7)
    `CHK("p_ale_cnt", ale_cnt_b, 1)
    `CHK("p_wn_cnt", wn_cnt_b, 2)
    `CHK("p_mid_cnt", mid_cnt_b, 4)
    `CHK("p_wrise", wrise_b, 1)
    `CHK("p_done_cnt", done_cnt_b, 1)

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mcs51_bus_master.md
Name: mcs51_bus_master

Overview:
- Cycle-accurate initiator for the multiplexed 8051-style external bus that the chip's configuration port responds to.
- Accepts write/read requests over a valid/ready handshake and drives cs_n, ale, abus, dbus, w_n and r_n with programmable phase widths.
- Used as the on-chip/bench driver for filter coefficient and timer programming, and for register read-back.

Parameters:
- ALE_CYC, 2, clocks with ale high (address phase); minimum 1.
- STROBE_CYC, 4, clocks with w_n or r_n low; minimum 2.
- HOLD_CYC, 1, clocks after strobe release with cs_n still low; minimum 1, so the responder sees the w_n rising edge while cs_n is low.

Ports:
- clock  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when valid and ready are both high.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  16  bus address; [15:8] goes on abus, [7:0] is multiplexed on dbus.
- req_wdata  in  8  write data.
- done  out  1  one-cycle pulse at transaction end.
- rdata  out  8  read data, valid when done is high and the transaction was a read.
- cs_n  out  1  chip select.
- ale  out  1  address latch enable.
- abus  out  8  high address byte.
- w_n  out  1  write strobe.
- r_n  out  1  read strobe.
- dbus_o  out  8  data bus drive value.
- dbus_oe  out  1  data bus output enable; the pad tristate lives outside this block.
- dbus_i  in  8  data bus input.

Behaviour:
- Reset values: cs_n=1, ale=0, w_n=1, r_n=1, dbus_oe=0, dbus_o=0, abus=0, done=0, rdata=0, req_ready=0 during reset. State=IDLE.
- Reset mid-transaction: the next edge aborts to IDLE with reset values. No done pulse is issued.
- State IDLE:
  - req_ready=1, cs_n=1.
  - On handshake, capture addr, wdata and write into registers, load the phase counter with ALE_CYC-1, go to ADDR.
- State ADDR (ALE_CYC clocks):
  - cs_n=0, ale=1, abus=addr[15:8], dbus_o=addr[7:0], dbus_oe=1.
  - When the counter reaches 0, go to LATCH.
- State LATCH (1 clock):
  - ale=0, address still driven.
  - Load counter with STROBE_CYC-1, go to STROBE.
- State STROBE (STROBE_CYC clocks):
  - Write: w_n=0, dbus_o=wdata, dbus_oe=1.
  - Read: r_n=0, dbus_oe=0.
  - On the last STROBE clock, a read registers dbus_i into rdata.
  - Load counter with HOLD_CYC-1, go to HOLD.
- State HOLD (HOLD_CYC clocks):
  - w_n=1, r_n=1, cs_n=0, abus held.
  - Write keeps dbus_o=wdata with dbus_oe=1; read keeps dbus_oe=0.
  - Exit to IDLE with done=1 for exactly one clock, coincident with the first IDLE cycle.
- rdata holds its value until the next read completes.
- Transaction length: ALE_CYC+1+STROBE_CYC+HOLD_CYC clocks with cs_n low. With defaults that is 8.
- Back-to-back: a request presented in the done cycle is accepted. cs_n is high for exactly 1 clock between transactions.
- Outputs are registered (Moore). The phase counter is 3 bits, sized for parameters up to 8. Parameter values below the minimums are a fatal elaboration error.

Optional Feature:
- MCS51_BUS_GAP_EN defined:
  - Add state GAP after HOLD: 1 clock with cs_n=1, req_ready=0, done=0.
  - done moves to the first IDLE cycle after GAP.
  - Minimum cs_n-high time between transactions becomes 2 clocks.
- Undefined: HOLD goes directly to IDLE as above.

Decomposition:
- Package mcs51_bus_pkg:
  - State enum IDLE/ADDR/LATCH/STROBE/HOLD/GAP.
  - Phase counter width constant.
  - Default phase constants.
- One sub-module, mcs51_phase_timer: a loadable down-counter that raises a zero flag. The FSM lives in the top of the block.

Test Plan:
- Reset, then write addr=16'h1234 wdata=8'hA5:
  - ale high 2 clocks with abus=8'h12, dbus_o=8'h34.
  - w_n low 4 clocks with dbus_o=8'hA5.
  - cs_n low 8 clocks total; done 1 pulse.
- Read addr=16'h0210 with dbus_i=8'h3C during strobe:
  - r_n low 4 clocks, dbus_oe=0 throughout the strobe.
  - rdata=8'h3C with done.
- Two back-to-back writes (req_valid held): cs_n high exactly 1 clock between them, or 2 clocks with MCS51_BUS_GAP_EN; second abus value correct.
- rst asserted in the third STROBE clock of a write: next edge shows cs_n=1, w_n=1, dbus_oe=0; no done pulse; a new request is accepted afterwards.
- Parameters ALE_CYC=1, STROBE_CYC=2, HOLD_CYC=3:
  - Phase lengths 1/1/2/3, cs_n low 7 clocks.
  - w_n rising edge occurs while cs_n=0.
- req_valid toggling with req_ready=0 during a transaction: no capture, and captured addr/wdata stay stable while req_addr changes.
